// File: rtl/bus_timer.sv
// ============================================================================
//  Module      : bus_timer
//  Description : Memory-mapped up-counting timer with match/overflow, optional
//                auto-reload and interrupt. Optional clock prescaler is built
//                when BUS_TIMER_PRESCALER_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_timer #(
    parameter int DATA_WIDTH = 32,
    parameter int PRE_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs,
    input  logic                  wen,
    input  logic [3:0]            addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  irq
);

    localparam logic [3:0] C_ADDR_CTRL = 4'd0;
    localparam logic [3:0] C_ADDR_CNT  = 4'd1;
    localparam logic [3:0] C_ADDR_AR   = 4'd2;
    localparam logic [3:0] C_ADDR_STAT = 4'd3;
    localparam logic [3:0] C_ADDR_PRE  = 4'd4;

    localparam logic [DATA_WIDTH-1:0] C_CNT_ONE = DATA_WIDTH'(1);

    logic                  r_run;
    logic                  r_autoreload;
    logic                  r_ie;
    logic                  r_ovf;
    logic [DATA_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0] r_ar;

    logic                  w_wr;
    logic                  w_wr_ctrl;
    logic                  w_wr_cnt;
    logic                  w_wr_ar;
    logic                  w_wr_stat;
    logic                  w_pre_hit;
    logic                  w_tick;
    logic                  w_tick_eff;
    logic                  w_match;
    logic                  w_ovf_evt;
    logic                  w_ovf_clr;
    logic [PRE_WIDTH-1:0]  w_pre_val;
    logic [DATA_WIDTH-1:0] w_pre_ext;
    logic [DATA_WIDTH-1:0] w_ctrl_rd;
    logic [DATA_WIDTH-1:0] w_stat_rd;

    assign w_wr      = cs & wen;
    assign w_wr_ctrl = w_wr && (addr == C_ADDR_CTRL);
    assign w_wr_cnt  = w_wr && (addr == C_ADDR_CNT);
    assign w_wr_ar   = w_wr && (addr == C_ADDR_AR);
    assign w_wr_stat = w_wr && (addr == C_ADDR_STAT);

`ifdef BUS_TIMER_PRESCALER_EN
    localparam logic [PRE_WIDTH-1:0] C_PRE_ONE = PRE_WIDTH'(1);

    logic [PRE_WIDTH-1:0] r_pre;
    logic [PRE_WIDTH-1:0] r_pscnt;
    logic                 w_wr_pre;

    assign w_wr_pre  = w_wr && (addr == C_ADDR_PRE);
    assign w_pre_hit = (r_pscnt == r_pre);
    assign w_pre_val = r_pre;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre   <= '0;
            r_pscnt <= '0;
        end else begin
            if (w_wr_pre) begin
                r_pre <= din[PRE_WIDTH-1:0];
            end
            // Reprogramming restarts the divide phase from a known point.
            if (w_wr_pre || w_wr_ctrl) begin
                r_pscnt <= '0;
            end else if (r_run) begin
                r_pscnt <= w_pre_hit ? '0 : (r_pscnt + C_PRE_ONE);
            end
        end
    end
`else
    assign w_pre_hit = 1'b1;
    assign w_pre_val = '0;
`endif

    assign w_tick     = r_run & w_pre_hit;
    // A software CNT load or a RUN-clearing CTRL write takes priority over the tick.
    assign w_tick_eff = w_tick & ~w_wr_cnt & ~(w_wr_ctrl & ~din[0]);
    assign w_match    = (r_cnt == r_ar);
    assign w_ovf_evt  = w_tick_eff & w_match;
    assign w_ovf_clr  = w_wr_stat & din[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_run        <= 1'b0;
            r_autoreload <= 1'b0;
            r_ie         <= 1'b0;
            r_ovf        <= 1'b0;
            r_cnt        <= '0;
            r_ar         <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_run        <= din[0];
                r_autoreload <= din[1];
                r_ie         <= din[2];
            end else if (w_ovf_evt && !r_autoreload) begin
                r_run <= 1'b0;
            end

            if (w_wr_cnt) begin
                r_cnt <= din;
            end else if (w_tick_eff) begin
                r_cnt <= w_match ? '0 : (r_cnt + C_CNT_ONE);
            end

            if (w_wr_ar) begin
                r_ar <= din;
            end

            // A new overflow wins over a simultaneous clear.
            r_ovf <= w_ovf_evt | (r_ovf & ~w_ovf_clr);
        end
    end

    assign irq = r_ovf & r_ie;

    always_comb begin
        w_pre_ext                = '0;
        w_pre_ext[PRE_WIDTH-1:0] = w_pre_val;
        w_ctrl_rd                = '0;
        w_ctrl_rd[2:0]           = {r_ie, r_autoreload, r_run};
        w_stat_rd                = '0;
        w_stat_rd[0]             = r_ovf;
    end

    always_comb begin
        dout = '0;
        if (cs) begin
            case (addr)
                C_ADDR_CTRL: dout = w_ctrl_rd;
                C_ADDR_CNT:  dout = r_cnt;
                C_ADDR_AR:   dout = r_ar;
                C_ADDR_STAT: dout = w_stat_rd;
                C_ADDR_PRE:  dout = w_pre_ext;
                default:     dout = '0;
            endcase
        end
    end

endmodule

`default_nettype wire
